// File: rtl/regfile_hilo_md.sv
// Decode-stage register file with write bypass, optional zero register,
// and HI/LO registers fed by an iterative multiply/divide unit.
module regfile_hilo_md #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned ADR_W    = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADR_W-1:0]  Radr1,
    input  logic [ADR_W-1:0]  Radr2,
    output logic [DATA_W-1:0] Rdata1,
    output logic [DATA_W-1:0] Rdata2,
    input  logic              WE,
    input  logic [ADR_W-1:0]  Wadr,
    input  logic [DATA_W-1:0] Wdata,
    input  logic              md_start,
    input  logic [1:0]        md_op,
    input  logic [DATA_W-1:0] md_a,
    input  logic [DATA_W-1:0] md_b,
    output logic              md_busy,
    output logic              md_done,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [DATA_W-1:0] mt_data,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned ACC_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } md_state_t;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_ok;

    md_state_t         state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] opb;
    logic [1:0]        op_q;
    logic              sign_q, sign_r, bzero;
    logic              busy_q, done_q;
    logic [DATA_W-1:0] hi_q, lo_q;

    logic              sa, sb;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic [DATA_W:0]   mul_sum, trial, diff;
    logic              ge;
    logic [DATA_W-1:0] rem_n;
    logic [ACC_W-1:0]  acc_step, prod;
    logic [DATA_W-1:0] quo, rem, res_hi, res_lo;

    // A write to register 0 is dropped when it is hard-wired to zero
    assign wr_ok = WE && !((ZERO_REG != 0) && (Wadr == '0));

    // GPR array write port
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[Wadr] <= Wdata;
        end
    end

    // Combinational read ports with write-to-read bypass
    always_comb begin
        Rdata1 = regs[Radr1];
        Rdata2 = regs[Radr2];
        if (wr_ok && (Wadr == Radr1)) Rdata1 = Wdata;
        if (wr_ok && (Wadr == Radr2)) Rdata2 = Wdata;
        if ((ZERO_REG != 0) && (Radr1 == '0)) Rdata1 = '0;
        if ((ZERO_REG != 0) && (Radr2 == '0)) Rdata2 = '0;
    end

    // md state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_n;
    end

    // md next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (md_start) state_n = S_RUN;
            S_RUN:  if (cnt == CNT_W'(DATA_W - 1)) state_n = S_FIX;
            S_FIX:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Operand magnitudes, one shift-add / restoring-divide step, sign fix-up
    always_comb begin
        sa    = ~md_op[0] & md_a[DATA_W-1];
        sb    = ~md_op[0] & md_b[DATA_W-1];
        mag_a = sa ? (~md_a + DATA_W'(1)) : md_a;
        mag_b = sb ? (~md_b + DATA_W'(1)) : md_b;

        mul_sum = {1'b0, acc[ACC_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);
        trial   = {acc[ACC_W-1:DATA_W], acc[DATA_W-1]};
        ge      = trial >= {1'b0, opb};
        diff    = trial - {1'b0, opb};
        rem_n   = ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];

        if (op_q[1]) acc_step = {rem_n, acc[DATA_W-2:0], ge};
        else         acc_step = {mul_sum, acc[DATA_W-1:1]};

        prod = acc;
        if (!op_q[0] && sign_q) prod = ~acc + ACC_W'(1);

        // Divide-by-zero keeps the all-ones quotient; remainder sign fix restores md_a
        quo = acc[DATA_W-1:0];
        rem = acc[ACC_W-1:DATA_W];
        if (!op_q[0] && sign_q && !bzero) quo = ~quo + DATA_W'(1);
        if (!op_q[0] && sign_r)           rem = ~rem + DATA_W'(1);

        res_hi = op_q[1] ? rem : prod[ACC_W-1:DATA_W];
        res_lo = op_q[1] ? quo : prod[DATA_W-1:0];
    end

    // md datapath, HI/LO registers and handshake flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            op_q   <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            bzero  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= (state_n != S_IDLE);
            done_q <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (md_start) begin
                        acc    <= {{DATA_W{1'b0}}, mag_a};
                        opb    <= mag_b;
                        op_q   <= md_op;
                        sign_q <= sa ^ sb;
                        sign_r <= sa;
                        bzero  <= (md_b == '0);
                        cnt    <= '0;
                    end
                    if (mthi_we) hi_q <= mt_data;
                    if (mtlo_we) lo_q <= mt_data;
                end
                S_RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
                default: ;
            endcase
        end
    end

    assign md_busy = busy_q;
    assign md_done = done_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule

// File: tb/tb_regfile_hilo_md.sv
// Self-checking bench for regfile_hilo_md (DATA_W=32, NREG=32, ZERO_REG=1).
module tb_regfile_hilo_md;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [4:0]  Radr1 = '0, Radr2 = '0, Wadr = '0;
    logic [31:0] Rdata1, Rdata2, Wdata = '0;
    logic        WE = 1'b0;
    logic        md_start = 1'b0;
    logic [1:0]  md_op = '0;
    logic [31:0] md_a = '0, md_b = '0;
    logic        md_busy, md_done;
    logic        mthi_we = 1'b0, mtlo_we = 1'b0;
    logic [31:0] mt_data = '0;
    logic [31:0] Hi, Lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] mem [32];

    regfile_hilo_md dut (
        .CLK(CLK), .RST(RST),
        .Radr1(Radr1), .Radr2(Radr2), .Rdata1(Rdata1), .Rdata2(Rdata2),
        .WE(WE), .Wadr(Wadr), .Wdata(Wdata),
        .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
        .md_busy(md_busy), .md_done(md_done),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
        .Hi(Hi), .Lo(Lo)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_vec_t;

    md_vec_t vecs [10];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference GPR read: zero register, then bypass of the pending write, then array
    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (WE && Wadr == a) return Wdata;
        return mem[a];
    endfunction

    // Reference md result using plain 64-bit arithmetic
    task automatic md_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin p = sa * sb; {hi, lo} = p; end
            2'd1: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
            2'd2: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
            end
            default: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100 && !md_done; i++) tick();
        check(name, 32'(md_done), 32'd1);
    endtask

    // Issue one md op, check busy length, result and single-cycle done pulse
    task automatic run_md(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int busy_n;
        bit seen;
        md_op = op; md_a = a; md_b = b; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (md_done) seen = 1'b1;
            else begin
                if (md_busy) busy_n++;
                tick();
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_busy_cycles"}, 32'(busy_n), 32'd33);
        check({name, "_hi"}, Hi, ehi);
        check({name, "_lo"}, Lo, elo);
        tick();
        check({name, "_done_pulse"}, 32'(md_done), 32'd0);
    endtask

    initial begin
        logic [31:0] ehi, elo;
        logic [4:0]  r;
        int          dcnt, bcnt;

        vecs[0] = '{"mult_neg",   2'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{"mult_min",   2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[2] = '{"multu_max",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
        vecs[3] = '{"divu_100_7", 2'd3, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4] = '{"div_m7_2",   2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[5] = '{"div_7_m2",   2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[6] = '{"divu_9_0",   2'd3, 32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF};
        vecs[7] = '{"div_m9_0",   2'd2, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF};
        vecs[8] = '{"div_ovf",    2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[9] = '{"multu_zero", 2'd1, 32'd0,         32'h1234_5678, 32'd0,         32'd0};

        for (int i = 0; i < 32; i++) mem[i] = '0;

        // Reset state
        tick(); tick();
        Radr1 = 5'd3; Radr2 = 5'd17;
        #1;
        check("rst_hi", Hi, 32'd0);
        check("rst_lo", Lo, 32'd0);
        check("rst_busy", 32'(md_busy), 32'd0);
        check("rst_done", 32'(md_done), 32'd0);
        check("rst_rd1", Rdata1, 32'd0);
        check("rst_rd2", Rdata2, 32'd0);
        RST = 1'b1;
        tick();

        // Fill r1..r31 and read back on both ports
        for (int n = 1; n < 32; n++) begin
            WE = 1'b1; Wadr = 5'(n); Wdata = 32'h100 + 32'(n);
            mem[n] = Wdata;
            tick();
        end
        WE = 1'b0;
        for (int n = 0; n < 32; n++) begin
            Radr1 = 5'(n); Radr2 = 5'(31 - n);
            #1;
            check("fill_rd1", Rdata1, (n == 0) ? 32'd0 : 32'h100 + 32'(n));
            check("fill_rd2", Rdata2, (n == 31) ? 32'd0 : 32'h100 + 32'(31 - n));
        end

        // Writes to r0 are dropped and never bypassed
        tick();
        WE = 1'b1; Wadr = 5'd0; Wdata = 32'hDEAD_BEEF; Radr1 = 5'd0; Radr2 = 5'd7;
        #1;
        check("r0_nobypass", Rdata1, 32'd0);
        tick();
        WE = 1'b0;
        #1;
        check("r0_after", Rdata1, 32'd0);
        check("r7_after", Rdata2, 32'h107);

        // Same-cycle bypass on both ports
        tick();
        WE = 1'b1; Wadr = 5'd5; Wdata = 32'hA5A5_A5A5; Radr1 = 5'd5; Radr2 = 5'd5;
        #1;
        check("bypass_rd1", Rdata1, 32'hA5A5_A5A5);
        check("bypass_rd2", Rdata2, 32'hA5A5_A5A5);
        mem[5] = Wdata;
        tick();

        // Random GPR traffic against the array model
        for (int i = 0; i < 60; i++) begin
            WE = 1'($urandom_range(0, 1));
            Wadr = 5'($urandom_range(0, 31));
            Wdata = $urandom;
            r = 5'($urandom_range(0, 31));
            Radr1 = ($urandom_range(0, 1) == 1) ? Wadr : r;
            Radr2 = 5'($urandom_range(0, 31));
            #1;
            check("rand_rd1", Rdata1, ref_read(Radr1));
            check("rand_rd2", Rdata2, ref_read(Radr2));
            if (WE && Wadr != 0) mem[Wadr] = Wdata;
            tick();
        end
        WE = 1'b0;

        // Directed md vectors
        for (int i = 0; i < 10; i++)
            run_md(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // Random md operations against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            md_ref(op, a, b, ehi, elo);
            run_md("rand_md", op, a, b, ehi, elo);
        end

        // MT with simultaneous start lands now; mid-run start and MT are ignored
        md_op = 2'd0; md_a = 32'd6; md_b = 32'd7; md_start = 1'b1;
        mthi_we = 1'b1; mt_data = 32'h1234;
        tick();
        md_start = 1'b0; mthi_we = 1'b0;
        check("mt_with_start_hi", Hi, 32'h1234);
        check("start_busy", 32'(md_busy), 32'd1);
        repeat (5) tick();
        md_op = 2'd3; md_a = 32'd999; md_b = 32'd3; md_start = 1'b1;
        mthi_we = 1'b1; mt_data = 32'h9999;
        tick();
        md_start = 1'b0; mthi_we = 1'b0;
        check("midrun_mt_ignored", Hi, 32'h1234);
        wait_done("midrun_done");
        check("midrun_hi", Hi, 32'd0);
        check("midrun_lo", Lo, 32'd42);

        // Start accepted in the done cycle
        md_op = 2'd3; md_a = 32'd100; md_b = 32'd7; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        check("b2b_busy", 32'(md_busy), 32'd1);
        tick();
        wait_done("b2b_done");
        check("b2b_hi", Hi, 32'd2);
        check("b2b_lo", Lo, 32'd14);
        tick();

        // MTLO alone, then both strobes together
        mtlo_we = 1'b1; mt_data = 32'h55;
        tick();
        mtlo_we = 1'b0;
        check("mtlo_lo", Lo, 32'h55);
        check("mtlo_hi_kept", Hi, 32'd2);
        mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'hCAFE;
        tick();
        mthi_we = 1'b0; mtlo_we = 1'b0;
        check("mtboth_hi", Hi, 32'hCAFE);
        check("mtboth_lo", Lo, 32'hCAFE);

        // Reset in the middle of a divide aborts it cleanly
        md_op = 2'd3; md_a = 32'd100; md_b = 32'd7; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        repeat (10) tick();
        RST = 1'b0;
        #1;
        check("abort_hi", Hi, 32'd0);
        check("abort_lo", Lo, 32'd0);
        check("abort_busy", 32'(md_busy), 32'd0);
        check("abort_done", 32'(md_done), 32'd0);
        tick(); tick();
        RST = 1'b1;
        dcnt = 0; bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (md_done) dcnt++;
            if (md_busy) bcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        check("abort_no_busy", 32'(bcnt), 32'd0);
        check("abort_lo_held", Lo, 32'd0);
        run_md("post_reset_divu", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/regfile_hilo_md.md
Name: regfile_hilo_md

Overview:
Parametrised successor to the decode-stage register file. Provides a GPR array with two combinational read ports, one write port with write-to-read bypass, and an optional hard-wired zero register. Adds HI/LO special registers fed by an iterative multiply/divide unit with a start/busy/done handshake. It sits in the decode stage; MFHI/MFLO read the Hi/Lo outputs directly.

Parameters:
DATA_W, 32, width of GPRs, HI, LO and md operands (even, >= 8)
NREG, 32, number of GPRs (power of two)
ADR_W, 5, register address width, must equal log2(NREG)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
Radr1  in  ADR_W  read address, port 1
Radr2  in  ADR_W  read address, port 2
Rdata1  out  DATA_W  read data, port 1 (combinational)
Rdata2  out  DATA_W  read data, port 2 (combinational)
WE  in  1  GPR write enable
Wadr  in  ADR_W  GPR write address
Wdata  in  DATA_W  GPR write data
md_start  in  1  start an md operation (sampled only in IDLE)
md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
md_a  in  DATA_W  multiplicand / dividend (rs)
md_b  in  DATA_W  multiplier / divisor (rt)
md_busy  out  1  md unit occupied
md_done  out  1  one-cycle pulse: HI/LO just updated by md
mthi_we  in  1  MTHI write strobe
mtlo_we  in  1  MTLO write strobe
mt_data  in  DATA_W  data for MTHI/MTLO
Hi  out  DATA_W  HI register
Lo  out  DATA_W  LO register

Behaviour:
- Reset (RST=0, async): all GPRs, HI and LO cleared to 0; FSM to IDLE; md_busy=0; md_done=0. A reset mid-operation aborts it; no HI/LO write and no md_done.
- GPR write: on rising edge if WE=1; dropped if ZERO_REG=1 and Wadr=0.
- GPR read: combinational. If WE=1, Wadr==RadrN, and the write is not dropped, RdataN=Wdata (bypass). Otherwise RdataN=regs[RadrN]. With ZERO_REG=1, RadrN=0 always reads 0.
- md FSM states: IDLE, RUN, FIX.
- IDLE: on md_start=1, latch the op and operand magnitudes (|a| and |b| for signed ops, raw values for unsigned ops). Latch sign_q = sa^sb and sign_r = sa. Set counter=0 and go to RUN.
- RUN: one bit per cycle for exactly DATA_W cycles.
  - Multiply: shift-add into a 2*DATA_W accumulator.
  - Divide: restoring division, with quotient and remainder registers.
  - After the last iteration, go to FIX.
- FIX: apply signs.
  - Signed multiply: negate the full 2*DATA_W product if sign_q.
  - Signed divide: negate the quotient if sign_q; negate the remainder if sign_r.
  - On the FIX-exit edge, write HI/LO and go to IDLE. md_done=1 for the following cycle only.
- Result mapping:
  - MULT/MULTU: HI = upper product half, LO = lower half.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (md_b=0): LO = all ones, HI = md_a unmodified. Latency is unchanged.
- Signed overflow, most-negative / -1: result wraps (LO = most-negative, HI = 0). No trap.
- md_busy=1 in RUN and FIX, i.e. DATA_W+1 cycles starting the edge after md_start is accepted.
- Latency: start accepted at edge 0; HI/LO valid after edge DATA_W+1; md_done high in the cycle after that edge.
- md_start while md_busy=1 is ignored; operands are not re-latched.
- md_start on the same cycle md_done is high is accepted (FSM is IDLE).
- MTHI/MTLO: write at the edge when the strobe=1 and the FSM is IDLE or starting; ignored while md_busy=1.
- Simultaneous MT strobe and md_start: the MT write takes effect now; the md result overwrites it later.
- mthi_we and mtlo_we both set: both registers take mt_data.
- Hi/Lo are registered outputs with no bypass of mt_data.

Test Plan:
1. DATA_W=32. Write regs 1..31 with the value 0x100+n, read both ports; then write r0=0xDEADBEEF -> reads r0=0, rn=0x100+n.
2. WE=1, Wadr=5, Wdata=0xA5A5A5A5, Radr1=Radr2=5 in the same cycle -> both Rdata=0xA5A5A5A5 before the edge.
3. MULT a=-3, b=5 -> md_busy=1 for 33 cycles; Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; md_done pulse 1 cycle. MULT 0x80000000*0x80000000 -> Hi=0x40000000, Lo=0.
4. DIVU 100/7 -> Lo=14, Hi=2. DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 9/0 -> Lo=0xFFFFFFFF, Hi=9.
5. Start MULT, pulse md_start with new operands and mthi_we (mt_data=0x1234) mid-RUN -> both ignored; the original result is delivered. MTLO 0x55 while IDLE -> Lo=0x55 next cycle.
6. Start DIVU, assert RST=0 at cycle 10 -> Hi=Lo=0, md_busy=0, no md_done. After release, a new DIVU 100/7 completes normally.
